// File: rtl/i2c_slave.sv
// I2C target with oversampled SCL/SDA, START/STOP detection and 7-bit address match.
// Write bytes are received and ACKed; read bytes come from tx_data. SDA is open-drain via sda_oe.
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_WRITE_ACK = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_READ_ACK  = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic       r_bit_done;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_match;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_busy;

  logic       w_scl_s;
  logic       w_sda_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_shift_in;

  // Idle bus is high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  assign w_start    = r_sda_d & ~w_sda_s & w_scl_s & r_scl_d;
  assign w_stop     = ~r_sda_d & w_sda_s & w_scl_s & r_scl_d;
  assign w_shift_in = {r_shift[6:0], w_sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_bit_done <= 1'b0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_match    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_stop) begin
        r_state    <= S_IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_bit_cnt  <= 3'd0;
        r_bit_done <= 1'b0;
      end else if (w_start) begin
        r_state    <= S_ADDR;
        r_sda_oe   <= 1'b0;
        r_bit_cnt  <= 3'd0;
        r_bit_done <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_oe <= 1'b0;
          end

          // The SCL fall right after START is ignored because no bit is done yet.
          S_ADDR: begin
            if (w_scl_rise && !r_bit_done) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_bit_done <= 1'b1;
                r_match    <= (w_shift_in[7:1] == SLAVE_ADDR);
                r_rw       <= w_sda_s;
              end
            end else if (w_scl_fall && r_bit_done) begin
              r_bit_done <= 1'b0;
              r_bit_cnt  <= 3'd0;
              if (r_match) begin
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= S_ADDR_ACK;
              end else begin
                r_state  <= S_WAIT_STOP;
              end
            end
          end

          S_ADDR_ACK: begin
            if (w_scl_rise && r_rw) begin
              r_tx_req <= 1'b1;
            end else if (w_scl_fall) begin
              r_bit_cnt  <= 3'd0;
              r_bit_done <= 1'b0;
              if (r_rw) begin
                r_shift  <= tx_data;
                r_sda_oe <= ~tx_data[7];
                r_state  <= S_READ;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_WRITE;
              end
            end
          end

          S_WRITE: begin
            if (w_scl_rise && !r_bit_done) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_bit_done <= 1'b1;
                r_rx_data  <= w_shift_in;
                r_rx_valid <= 1'b1;
              end
            end else if (w_scl_fall && r_bit_done) begin
              r_bit_done <= 1'b0;
              r_bit_cnt  <= 3'd0;
              r_sda_oe   <= 1'b1;
              r_state    <= S_WRITE_ACK;
            end
          end

          S_WRITE_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe   <= 1'b0;
              r_bit_cnt  <= 3'd0;
              r_bit_done <= 1'b0;
              r_state    <= S_WRITE;
            end
          end

          // Bit 7 is already on the bus on entry; each fall advances one bit.
          S_READ: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= 3'd0;
                r_sda_oe  <= 1'b0;
                r_state   <= S_READ_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_sda_oe  <= ~r_shift[6];
                r_shift   <= {r_shift[6:0], 1'b0};
              end
            end
          end

          S_READ_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda_s) begin
                r_tx_req <= 1'b1;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_WAIT_STOP;
              end
            end else if (w_scl_fall) begin
              r_shift   <= tx_data;
              r_sda_oe  <= ~tx_data[7];
              r_bit_cnt <= 3'd0;
              r_state   <= S_READ;
            end
          end

          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master plus a transaction-level expectation model
// (address match, ACK slots, received and transmitted bytes) driven by directed and random traffic.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_got[$];
  int         n_txreq = 0;
  int         n_oe    = 0;
  logic [7:0] tx_idx  = 8'd0;
  logic [7:0] tx_bytes [0:255];
  logic [7:0] xd [0:7];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (m_scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // User-side responder and monitors.
  always @(posedge clk) begin
    if (rx_valid) rx_got.push_back(rx_data);
    if (tx_req) begin
      tx_data <= tx_bytes[tx_idx];
      tx_idx  <= tx_idx + 8'd1;
      n_txreq <= n_txreq + 1;
    end
    if (sda_oe) n_oe <= n_oe + 1;
  end

  task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;    wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    s = sda_bus;  wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_line);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack_line);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // One transaction; expectations follow from address match, direction and the byte list.
  task automatic do_xfer(input string name, input logic [6:0] addr, input logic rw,
                         input int len, input logic send_stop);
    logic       s;
    logic       match;
    logic [7:0] got;
    int         rx_base;
    int         txr_base;
    int         oe_base;
    int         n_rx;
    match    = (addr == 7'h50);
    rx_base  = rx_got.size();
    txr_base = n_txreq;
    oe_base  = n_oe;
    for (int k = 0; k < len; k++) tx_bytes[8'(tx_idx + 8'(k))] = xd[k];
    $display("TXN %s addr=%02h rw=%0d len=%0d stop=%0d", name, addr, rw, len, send_stop);
    i2c_start();
    write_byte({addr, rw}, s);
    tb_check({name, " addr_ack"}, 32'(s), match ? 32'd0 : 32'd1);
    for (int k = 0; k < len; k++) begin
      if (!rw) begin
        write_byte(xd[k], s);
        tb_check({name, " data_ack"}, 32'(s), match ? 32'd0 : 32'd1);
      end else begin
        read_byte(k == len - 1, got);
        tb_check({name, " rd_byte"}, 32'(got), match ? 32'(xd[k]) : 32'hFF);
      end
    end
    tb_check({name, " busy"}, 32'(busy), 32'(match && !rw));
    n_rx = rx_got.size() - rx_base;
    tb_check({name, " rx_count"}, 32'(n_rx), (match && !rw) ? 32'(len) : 32'd0);
    for (int k = 0; k < n_rx && k < len; k++)
      tb_check({name, " rx_byte"}, 32'(rx_got[rx_base + k]), 32'(xd[k]));
    if (match && !rw)
      tb_check({name, " rx_data"}, 32'(rx_data), 32'(xd[len - 1]));
    tb_check({name, " tx_req_count"}, 32'(n_txreq - txr_base), (match && rw) ? 32'(len) : 32'd0);
    if (!match)
      tb_check({name, " oe_never"}, 32'(n_oe - oe_base), 32'd0);
    if (send_stop) begin
      i2c_stop();
      tb_check({name, " busy_after_stop"}, 32'(busy), 32'd0);
      tb_check({name, " oe_after_stop"}, 32'(sda_oe), 32'd0);
    end
  endtask

  initial begin
    logic       s;
    logic [6:0] a;
    logic       rw;
    int         len;
    int         rx_base;

    for (int i = 0; i < 256; i++) tx_bytes[i] = 8'h00;
    wait_clks(5);
    $display("TXN reset");
    tb_check("reset sda_oe", 32'(sda_oe), 32'd0);
    tb_check("reset rx_data", 32'(rx_data), 32'd0);
    tb_check("reset rx_valid", 32'(rx_valid), 32'd0);
    tb_check("reset tx_req", 32'(tx_req), 32'd0);
    tb_check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(5);

    xd[0] = 8'h3C; xd[1] = 8'hC3;
    do_xfer("write2", 7'h50, 1'b0, 2, 1'b1);

    xd[0] = 8'h55;
    do_xfer("wrong_addr", 7'h51, 1'b0, 1, 1'b1);

    xd[0] = 8'h96; xd[1] = 8'h0F;
    do_xfer("read2", 7'h50, 1'b1, 2, 1'b1);

    xd[0] = 8'h12;
    do_xfer("rs_write", 7'h50, 1'b0, 1, 1'b0);
    xd[0] = 8'hF0;
    do_xfer("rs_read", 7'h50, 1'b1, 1, 1'b1);
    tb_check("rs rx_data_kept", 32'(rx_data), 32'h12);

    // Reset pulsed in the low phase of data bit 4.
    $display("TXN reset_mid_write");
    i2c_start();
    write_byte(8'hA0, s);
    tb_check("rstmid addr_ack", 32'(s), 32'd0);
    rx_base = rx_got.size();
    clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
    m_sda = 1'b0;
    wait_clks(Q / 2);
    tb_check("rstmid busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    tb_check("rstmid busy_async", 32'(busy), 32'd0);
    tb_check("rstmid oe_async", 32'(sda_oe), 32'd0);
    tb_check("rstmid rx_data_async", 32'(rx_data), 32'd0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    i2c_stop();
    tb_check("rstmid no_rx", 32'(rx_got.size() - rx_base), 32'd0);
    xd[0] = 8'h77;
    do_xfer("after_rst", 7'h50, 1'b0, 1, 1'b1);

    // STOP injected after three data bits.
    $display("TXN stop_mid_byte");
    rx_base = rx_got.size();
    i2c_start();
    write_byte(8'hA0, s);
    tb_check("midstop addr_ack", 32'(s), 32'd0);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
    i2c_stop();
    wait_clks(4);
    tb_check("midstop no_rx", 32'(rx_got.size() - rx_base), 32'd0);
    tb_check("midstop busy", 32'(busy), 32'd0);
    tb_check("midstop oe", 32'(sda_oe), 32'd0);

    for (int t = 0; t < 20; t++) begin
      a   = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      rw  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) xd[k] = 8'($urandom_range(0, 255));
      do_xfer("rand", a, rw, len, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
